wb_regfile: RTL and testbench

Write-back register file for the single-issue WISC core. It consumes the 2-bit write-destination select produced by the decode-stage destination decoder together with the instruction word, and resolves the 3-bit destination register from it. Writes pass through a one-entry write-back staging register before committing to an 8 x 16-bit array. Two combinational read ports bypass the staged entry, so a value is readable the cycle after it is presented.

---
 rtl/wb_regfile.sv | 124 ++++++++++++
 tb/tb_wb_regfile.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile -- write-back register file for the single-issue WISC core.
//
// Resolves the architectural destination register from the decode-stage
// destination select and the instruction word, holds each write for one cycle
// in a staging register, and commits it to an 8 x DATA_W array on the
// following rising edge. Both read ports bypass the staged entry, so a write
// presented in cycle N is readable from cycle N+1 onward. The current-cycle
// wr_data is never forwarded to the read ports.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        asynchronous active-low reset, clears array and staging
//   instr      current instruction word, source of the destination fields
//   reg_dst    destination select: 00 Rd[4:2], 01 Rd[7:5], 10 Rs[10:8], 11 R7
//   reg_write  write request for this cycle
//   wr_data    data to write
//   rd_addr1   read port 1 address
//   rd_addr2   read port 2 address
//   rd_data1   read port 1 data (combinational)
//   rd_data2   read port 2 data (combinational)
//   wb_valid   staging register holds an uncommitted write
//   wb_dest    destination held in the staging register
// -----------------------------------------------------------------------------
module wb_regfile #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instr,
  input  logic [1:0]        reg_dst,
  input  logic              reg_write,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [2:0]        rd_addr1,
  input  logic [2:0]        rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              wb_valid,
  output logic [2:0]        wb_dest
);

  // Encodings of the decode-stage destination select.
  typedef enum logic [1:0] {
    DST_R_RD   = 2'b00,  // R-format Rd, instr[4:2]
    DST_I1_RD  = 2'b01,  // I-format-1 Rd, instr[7:5]
    DST_I2_RS  = 2'b10,  // I-format-2 / LBI Rs, instr[10:8]
    DST_LINK   = 2'b11   // link register for JAL/JALR
  } dst_sel_e;

  localparam logic [2:0] LINK_REG = 3'd7;

  logic [2:0]        dec_dest;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] regs [NREGS];

  // Only the three destination fields of the instruction matter here; the
  // remaining bits are folded into a sink so the intent is explicit.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[15:11], instr[1:0]};

  // ---------------------------------------------------------------------------
  // Destination decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written in always_comb gets a value on entry, so no
    // path through the case can leave it holding its old value (a latch).
    dec_dest = LINK_REG;
    case (dst_sel_e'(reg_dst))
      DST_R_RD:  dec_dest = instr[4:2];
      DST_I1_RD: dec_dest = instr[7:5];
      DST_I2_RS: dec_dest = instr[10:8];
      DST_LINK:  dec_dest = LINK_REG;
      default:   dec_dest = LINK_REG;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write-back staging register
  //   wb_valid follows reg_write every cycle; destination and data only load
  //   on a write so reg_dst and wr_data are don't-care otherwise.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid <= 1'b0;
      wb_dest  <= '0;
      wb_data  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      wb_valid <= reg_write;
      if (reg_write) begin
        wb_dest <= dec_dest;
        wb_data <= wr_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register array commit
  //   Commits the previously staged write on the same edge that loads the next
  //   one, so back-to-back writes to one register land in order. A reset while
  //   a write is staged discards it because the reset branch wins.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the array is reset, so it must be built from flops rather than a
      // RAM macro; acceptable at 8 entries and required for all-zero reads.
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_valid) begin
      regs[wb_dest] <= wb_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports: staged entry takes priority over the array contents, which
  // may still hold the older value for the same address.
  // ---------------------------------------------------------------------------
  assign rd_data1 = (wb_valid && (rd_addr1 == wb_dest)) ? wb_data : regs[rd_addr1];
  assign rd_data2 = (wb_valid && (rd_addr2 == wb_dest)) ? wb_data : regs[rd_addr2];

endmodule

// File: tb/tb_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile -- directed self-checking bench for wb_regfile.
// Inputs change 1 ns after a rising edge and outputs are checked 1 ns later,
// both well away from the active edge. Expected values are hand-derived.
// -----------------------------------------------------------------------------
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [15:0] instr;
  logic [1:0]  reg_dst;
  logic        reg_write;
  logic [15:0] wr_data;
  logic [2:0]  rd_addr1;
  logic [2:0]  rd_addr2;
  logic [15:0] rd_data1;
  logic [15:0] rd_data2;
  logic        wb_valid;
  logic [2:0]  wb_dest;

  int checks = 0;
  int errors = 0;

  wb_regfile #(.DATA_W(16), .NREGS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .instr     (instr),
    .reg_dst   (reg_dst),
    .reg_write (reg_write),
    .wr_data   (wr_data),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .rd_data1  (rd_data1),
    .rd_data2  (rd_data2),
    .wb_valid  (wb_valid),
    .wb_dest   (wb_dest)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance into the next cycle: just past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [1:0] dst, input logic [15:0] ins,
                       input logic [15:0] data);
    reg_write = we;
    reg_dst   = dst;
    instr     = ins;
    wr_data   = data;
  endtask

  initial begin
    rst       = 1'b0;
    instr     = 16'h0000;
    reg_dst   = 2'b00;
    reg_write = 1'b0;
    wr_data   = 16'h0000;
    rd_addr1  = 3'd0;
    rd_addr2  = 3'd0;

    // ---- Reset state ----
    #12;
    check("rst_rd1", rd_data1, 16'h0000);
    check("rst_rd2", rd_data2, 16'h0000);
    check("rst_valid", 16'(wb_valid), 16'h0000);
    check("rst_dest", 16'(wb_dest), 16'h0000);
    rst = 1'b1;

    // ---- Destination decode, instr = D6B4 ----
    step();
    drive(1'b1, 2'b00, 16'hD6B4, 16'h1111);
    rd_addr1 = 3'd5;
    #1;
    check("dec00_not_yet", rd_data1, 16'h0000);

    step();
    drive(1'b1, 2'b01, 16'hD6B4, 16'h1111);
    #1;
    check("dec00_dest", 16'(wb_dest), 16'h0005);
    check("dec00_valid", 16'(wb_valid), 16'h0001);
    check("dec00_rd", rd_data1, 16'h1111);

    step();
    drive(1'b1, 2'b10, 16'hD6B4, 16'h1111);
    #1;
    check("dec01_dest", 16'(wb_dest), 16'h0005);
    check("dec01_rd", rd_data1, 16'h1111);

    step();
    drive(1'b1, 2'b11, 16'hD6B4, 16'h1111);
    rd_addr2 = 3'd6;
    #1;
    check("dec10_dest", 16'(wb_dest), 16'h0006);
    check("dec10_rd", rd_data2, 16'h1111);

    step();
    drive(1'b0, 2'b00, 16'h0000, 16'h0000);
    rd_addr1 = 3'd7;
    #1;
    check("dec11_dest", 16'(wb_dest), 16'h0007);
    check("dec11_valid", 16'(wb_valid), 16'h0001);
    check("dec11_rd", rd_data1, 16'h1111);

    step();
    rd_addr1 = 3'd5;
    rd_addr2 = 3'd6;
    #1;
    check("dec_idle_valid", 16'(wb_valid), 16'h0000);
    check("dec_arr_r5", rd_data1, 16'h1111);
    check("dec_arr_r6", rd_data2, 16'h1111);
    rd_addr1 = 3'd7;
    rd_addr2 = 3'd0;
    #1;
    check("dec_arr_r7", rd_data1, 16'h1111);
    check("dec_arr_r0", rd_data2, 16'h0000);

    // ---- Bypass: R3 = BEEF (instr[4:2] = 011) ----
    step();
    drive(1'b1, 2'b00, 16'h000C, 16'hBEEF);
    rd_addr1 = 3'd3;
    #1;
    check("byp_n_old", rd_data1, 16'h0000);

    step();
    drive(1'b0, 2'b00, 16'h0000, 16'h0000);
    #1;
    check("byp_n1_rd", rd_data1, 16'hBEEF);
    check("byp_n1_valid", 16'(wb_valid), 16'h0001);
    check("byp_n1_dest", 16'(wb_dest), 16'h0003);

    step();
    #1;
    check("byp_n2_rd", rd_data1, 16'hBEEF);
    check("byp_n2_valid", 16'(wb_valid), 16'h0000);

    // ---- Back-to-back, same destination R2 (instr[4:2] = 010) ----
    step();
    drive(1'b1, 2'b00, 16'h0008, 16'h0001);
    rd_addr1 = 3'd2;
    #1;
    check("b2b_n", rd_data1, 16'h0000);

    step();
    drive(1'b1, 2'b00, 16'h0008, 16'h0002);
    #1;
    check("b2b_n1", rd_data1, 16'h0001);

    step();
    drive(1'b0, 2'b00, 16'h0000, 16'h0000);
    #1;
    check("b2b_n2", rd_data1, 16'h0002);

    step();
    #1;
    check("b2b_n3", rd_data1, 16'h0002);

    // ---- Back-to-back, different destinations: R1 then R0 ----
    step();
    drive(1'b1, 2'b00, 16'h0004, 16'hAAAA);
    rd_addr1 = 3'd1;
    rd_addr2 = 3'd0;
    #1;

    step();
    drive(1'b1, 2'b00, 16'h0000, 16'h5555);
    #1;
    check("diff_r1_byp", rd_data1, 16'hAAAA);

    step();
    drive(1'b0, 2'b00, 16'h0000, 16'h0000);
    #1;
    check("diff_r1_arr", rd_data1, 16'hAAAA);
    check("diff_r0_byp", rd_data2, 16'h5555);

    step();
    #1;
    check("diff_r0_arr", rd_data2, 16'h5555);

    // ---- Reset mid-write: R4 = CAFE staged, reset before commit ----
    step();
    drive(1'b1, 2'b00, 16'h0010, 16'hCAFE);
    rd_addr1 = 3'd4;
    #1;

    step();
    drive(1'b0, 2'b00, 16'h0000, 16'h0000);
    #1;
    check("rstw_staged_valid", 16'(wb_valid), 16'h0001);
    check("rstw_staged_rd", rd_data1, 16'hCAFE);
    rst = 1'b0;
    #1;
    check("rstw_valid_async", 16'(wb_valid), 16'h0000);
    check("rstw_rd_async", rd_data1, 16'h0000);
    for (int a = 0; a < 8; a++) begin
      rd_addr1 = 3'(a);
      rd_addr2 = 3'(7 - a);
      #1;
      check($sformatf("rst_all_p1_r%0d", a), rd_data1, 16'h0000);
      check($sformatf("rst_all_p2_r%0d", 7 - a), rd_data2, 16'h0000);
    end
    @(negedge clk);
    rst = 1'b1;

    step();
    rd_addr1 = 3'd4;
    rd_addr2 = 3'd3;
    #1;
    check("rstw_r4_dropped", rd_data1, 16'h0000);
    check("rstw_r3_cleared", rd_data2, 16'h0000);

    // ---- Dual read of link register after JAL-style write ----
    step();
    drive(1'b1, 2'b11, 16'h0000, 16'h0042);
    rd_addr1 = 3'd7;
    rd_addr2 = 3'd7;
    #1;
    check("jal_n_p1", rd_data1, 16'h0000);
    check("jal_n_p2", rd_data2, 16'h0000);

    step();
    drive(1'b0, 2'b00, 16'h0000, 16'h0000);
    #1;
    check("jal_byp_dest", 16'(wb_dest), 16'h0007);
    check("jal_byp_p1", rd_data1, 16'h0042);
    check("jal_byp_p2", rd_data2, 16'h0042);

    step();
    #1;
    check("jal_arr_p1", rd_data1, 16'h0042);
    check("jal_arr_p2", rd_data2, 16'h0042);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
